ram_reader: RTL and testbench
=============================

# ram_reader

Streaming read-side front end for a 1-read/1-write synchronous RAM whose read data appears one clock after the read enable. It turns a valid/ready address stream into a valid/ready data stream, absorbs the RAM's fixed read latency, and buffers data under response backpressure so that no returned word is lost and ordering is preserved. It sits between a consumer such as a fetch unit, DMA or FIFO pop side and the RAM's read port. The RAM's write port is not touched.

## Interface
- Width, 32, data word width in bits
- Depth, 256, RAM depth in words; address width AW = $clog2(Depth)

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  read request valid
- req_ready_o  out  1  request accepted when valid and ready are both high
- req_addr_i  in  AW  word address to read
- rsp_valid_o  out  1  response data valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_data_o  out  Width  read data, in request order
- ram_r_en_o  out  1  drives the RAM read enable
- ram_raddr_o  out  AW  drives the RAM read address
- ram_rdata_i  in  Width  RAM read data, valid the cycle after ram_r_en_o

## Operation
- Request fire is req_valid_i && req_ready_o. On a fire, ram_r_en_o = 1 and ram_raddr_o = req_addr_i, combinationally in the same cycle. With no fire, ram_r_en_o = 0 and ram_raddr_o = req_addr_i.
- The inflight flag is a register set on a request fire and cleared otherwise. When inflight = 1, ram_rdata_i holds the word for the oldest outstanding request.
- Response buffer: an in-order FIFO with 3 entries. count is 0..3.
- Credit rule: req_ready_o = (count + inflight < 3) && !rst_i. It has no combinational dependency on rsp_ready_i.
- Response valid and data with RAM_READER_BYPASS_EN:
  - rsp_valid_o = (count > 0) || inflight.
  - If count = 0, rsp_data_o = ram_rdata_i. Otherwise rsp_data_o is the buffer head.
- Response valid and data without RAM_READER_BYPASS_EN:
  - rsp_valid_o = (count > 0).
  - rsp_data_o is always the buffer head (a registered output).
- Response fire is rsp_valid_o && rsp_ready_i.
- Buffer push when inflight = 1:
  - With bypass: ram_rdata_i is pushed unless count = 0 and a response fire consumes it directly that cycle.
  - Without bypass: ram_rdata_i is always pushed.
- Buffer pop: a response fire pops the head when count > 0.
- A push and a pop in the same cycle leave count unchanged and keep order.
- Overflow cannot occur by construction of the credit rule. Verification asserts that count never exceeds 3 and that no push happens while count = 3 without a pop.
- Underflow cannot occur: rsp_valid_o = 0 when there is nothing to present.
- Reset, asserted at any time: count = 0, inflight = 0, buffer pointers = 0. Any in-flight RAM data is discarded, and the response arriving the cycle after reset deasserts is ignored.

## Timing
Reset values of outputs:
- req_ready_o = 0 while rst_i is high; 1 after release.
- rsp_valid_o = 0.
- ram_r_en_o = 0.
- rsp_data_o is don't-care while rsp_valid_o = 0.

Read latency from request fire to response valid:
- With bypass: 1 cycle (fire in cycle N, rsp_valid_o in cycle N+1).
- Without bypass: 2 cycles (rsp_valid_o in cycle N+2).

Throughput and backpressure:
- Sustained throughput is 1 request per cycle with req_valid_i and rsp_ready_i held high, in both configurations. Steady state is count=0, inflight=1 with bypass, and count=1, inflight=1 without.
- While rsp_ready_i is held low, at most 3 requests are accepted beyond those already consumed, then req_ready_o drops.
- req_ready_o rises the cycle after a response fire frees a credit.
- rsp_data_o is stable while rsp_valid_o = 1 and rsp_ready_i = 0.

## Configuration
- RAM_READER_BYPASS_EN defined: data from the RAM passes combinationally from ram_rdata_i to rsp_data_o when the buffer is empty, giving 1-cycle latency.
- RAM_READER_BYPASS_EN undefined: every word goes through the buffer, rsp_data_o is driven from flops, and latency is 2 cycles. Credit rule and ordering are identical in both cases.

## Test plan
- Single read: RAM preloaded so mem[5] = 32'hDEAD_BEEF; one request to address 5 with rsp_ready_i = 1 -> exactly one response of 32'hDEAD_BEEF, arriving at N+1 with bypass or N+2 without; ram_r_en_o high exactly one cycle.
- Streaming: addresses 0..15 back to back, rsp_ready_i = 1, mem[i] = i*3 -> 16 responses in order with values 0, 3, …, 45; req_ready_o never low after the first request.
- Backpressure: rsp_ready_i = 0 with continuous requests to addresses 8, 9, 10, 11, … -> exactly 3 requests accepted, then req_ready_o = 0; rsp_data_o holds mem[8]. Raising rsp_ready_i drains mem[8], mem[9], mem[10], then mem[11] and onward with no loss or duplication.
- Simultaneous push and pop at count = 2 with random rsp_ready_i toggling over 1000 requests -> scoreboard shows in-order exact match and count stays at or below 3.
- Reset mid-stream: rst_i asserted the cycle after a fire to address 2, with count = 2 -> outputs go to reset values immediately; after release, no stale data is presented; a new request to address 7 returns mem[7] only.
- Address edge: request address Depth-1 = 255 -> returns mem[255]; ram_raddr_o = 8'hFF.

Source files
------------

// File: rtl/ram_reader_if.sv
// Request/response stream and RAM read-port bundle for ram_reader.
// The slave modport is the reader's view; the master modport is the consumer/RAM side.
interface ram_reader_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [AW-1:0]    req_addr;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             ram_r_en;
   logic [AW-1:0]    ram_raddr;
   logic [WIDTH-1:0] ram_rdata;

   modport slave (
      input  req_valid, req_addr, rsp_ready, ram_rdata,
      output req_ready, rsp_valid, rsp_data, ram_r_en, ram_raddr
   );

   modport master (
      output req_valid, req_addr, rsp_ready, ram_rdata,
      input  req_ready, rsp_valid, rsp_data, ram_r_en, ram_raddr
   );
endinterface

// File: rtl/ram_reader.sv
// Read-side front end for a 1-cycle-latency synchronous RAM with a 3-entry response buffer.
// Define RAM_READER_BYPASS_EN to pass RAM data straight to the response when the buffer is empty.
module ram_reader #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   ram_reader_if.slave bus
);
   localparam logic [1:0] SLOTS = 2'd3;

   logic [1:0]       count_reg, count_next;
   logic [1:0]       wr_ptr_reg, rd_ptr_reg;
   logic             inflight_reg;
   logic [WIDTH-1:0] buf_mem [0:2];
   logic [WIDTH-1:0] head_data;
   logic [2:0]       used;
   logic             req_fire, rsp_fire, push, pop;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Credits count both buffered words and the word still coming out of the RAM.
   assign used          = {1'b0, count_reg} + {2'b00, inflight_reg};
   assign bus.req_ready = (used < {1'b0, SLOTS}) && !rst;
   assign req_fire      = bus.req_valid && bus.req_ready;
   assign bus.ram_r_en  = req_fire;
   assign bus.ram_raddr = bus.req_addr;

   assign head_data = buf_mem[rd_ptr_reg];
   assign rsp_fire  = bus.rsp_valid && bus.rsp_ready;
   assign pop       = rsp_fire && (count_reg != 2'd0);

`ifdef RAM_READER_BYPASS_EN
   assign bus.rsp_valid = (count_reg != 2'd0) || inflight_reg;
   assign bus.rsp_data  = (count_reg == 2'd0) ? bus.ram_rdata : head_data;
   // An empty buffer lets the consumer take the RAM word directly instead of storing it.
   assign push = inflight_reg && !((count_reg == 2'd0) && rsp_fire);
`else
   assign bus.rsp_valid = (count_reg != 2'd0);
   assign bus.rsp_data  = head_data;
   assign push          = inflight_reg;
`endif

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 2'd1;
         2'b01:   count_next = count_reg - 2'd1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg    <= 2'd0;
         wr_ptr_reg   <= 2'd0;
         rd_ptr_reg   <= 2'd0;
         inflight_reg <= 1'b0;
      end else begin
         count_reg    <= count_next;
         inflight_reg <= req_fire;
         if (push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == 2'(gi))) buf_mem[gi] <= bus.ram_rdata;
         end
      end
   endgenerate

   no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && (count_reg == SLOTS)));
endmodule

// File: tb/tb_ram_reader.sv
// Self-checking bench for ram_reader: directed scenarios plus random backpressure,
// compared against a queue-based model of accepted-but-unconsumed words.
module tb_ram_reader;
   localparam int WIDTH = 32;
   localparam int DEPTH = 256;
   localparam int AW    = 8;
`ifdef RAM_READER_BYPASS_EN
   localparam int LAT_SKEW = 0;
`else
   localparam int LAT_SKEW = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_reader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

   ram_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [WIDTH-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (bus.ram_r_en) bus.ram_rdata <= mem[bus.ram_raddr];
   end

   int               checks = 0;
   int               fails  = 0;
   logic [WIDTH-1:0] q[$];
   logic             last_fire = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check outputs, then advance the model past the next edge.
   task automatic step(input logic v, input logic [AW-1:0] a, input logic r, output logic fired);
      logic exp_ready, exp_valid;
      int   visible;
      @(negedge clk);
      bus.req_valid = v;
      bus.req_addr  = a;
      bus.rsp_ready = r;
      #1;
      exp_ready = !rst && (q.size() < 3);
      visible   = q.size() - (last_fire ? LAT_SKEW : 0);
      exp_valid = !rst && (visible > 0);
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
      chk("ram_r_en", 32'(bus.ram_r_en), 32'(v && exp_ready));
      chk("ram_raddr", 32'(bus.ram_raddr), 32'(a));
      if (exp_valid) chk("rsp_data", bus.rsp_data, q[0]);
      if (exp_valid && r) void'(q.pop_front());
      if (v && exp_ready) q.push_back(mem[a]);
      last_fire = v && exp_ready;
      fired = v && bus.req_ready;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = 1'b0;
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_ram_r_en", 32'(bus.ram_r_en), 32'd0);
      q.delete();
      last_fire = 1'b0;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain(input string tag);
      logic f;
      for (int i = 0; i < 20 && q.size() != 0; i++) step(1'b0, '0, 1'b1, f);
      chk(tag, 32'(q.size()), 32'd0);
   endtask

   initial begin
      logic           f;
      int             acc;
      int             cyc;
      logic [AW-1:0]  addr;

      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.rsp_ready = 1'b0;
      bus.ram_rdata = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem[5] = 32'hDEAD_BEEF;

      do_reset(2);

      // Single read to address 5.
      step(1'b1, 8'd5, 1'b1, f);
      drain("single_drain");

      // Streaming 0..15.
      for (int i = 0; i < 16; i++) mem[i] = 32'(i * 3);
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b1, f);
      drain("stream_drain");

      // Backpressure from address 8: only three words may be accepted.
      addr = 8'd8;
      acc  = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, addr, 1'b0, f);
         if (f) begin addr++; acc++; end
      end
      chk("stall_accepts", 32'(acc), 32'd3);
      for (int i = 0; i < 12; i++) begin
         step(1'b1, addr, 1'b1, f);
         if (f) addr++;
      end
      drain("bp_drain");

      // Reset mid-stream with two words buffered and one in flight.
      step(1'b1, 8'd0, 1'b0, f);
      step(1'b1, 8'd1, 1'b0, f);
      step(1'b1, 8'd2, 1'b0, f);
      do_reset(1);
      for (int i = 0; i < 3; i++) step(1'b0, 8'd7, 1'b1, f);
      step(1'b1, 8'd7, 1'b1, f);
      drain("post_reset_drain");

      // Top address.
      step(1'b1, 8'hFF, 1'b1, f);
      drain("edge_drain");

      // Random traffic with random response backpressure.
      acc = 0;
      cyc = 0;
      while (acc < 1000 && cyc < 8000) begin
         step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)), f);
         if (f) acc++;
         cyc++;
      end
      chk("rand_accepts", 32'(acc), 32'd1000);
      drain("rand_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
